// File: rtl/cam_pkg.sv
// Shared encodings and geometry helpers for the synthetic camera source.
package cam_pkg;

  localparam logic [1:0] CAM_MODE_RAMP  = 2'd0;
  localparam logic [1:0] CAM_MODE_BARS  = 2'd1;
  localparam logic [1:0] CAM_MODE_FIXED = 2'd2;
  localparam logic [1:0] CAM_MODE_STAMP = 2'd3;

  // RGB565: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [15:0] CAM_BAR_COLOR [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  function automatic int LINE_T(input int hActive, input int bpp, input int hBlank);
    return hActive * bpp + hBlank;
  endfunction

  function automatic int FRAME_L(input int vSync, input int vBack, input int vActive,
                                 input int vFront);
    return vSync + vBack + vActive + vFront;
  endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational test-pattern byte generator: pixel position and mode in, one
// output byte out. Multi-byte pixels are emitted MSB first.
module cam_pattern_gen
  import cam_pkg::*;
#(
  parameter int DW       = 8,
  parameter int H_ACTIVE = 640,
  parameter int BPP      = 2,
  parameter int FCW      = 16
) (
  input  logic [31:0]    x,
  input  logic [1:0]     b,
  input  logic [31:0]    y,
  input  logic [1:0]     mode,
  input  logic [15:0]    fixedPx,
  input  logic [FCW-1:0] frameCnt,
  output logic [DW-1:0]  data
);

  logic [31:0] rampVal;
  logic [31:0] barIdx;
  logic [2:0]  bar;
  logic [15:0] pixWord;
  logic [7:0]  pixByte;

  always_comb begin
    rampVal = x * BPP + {30'd0, b} + y;
    barIdx  = x * 8 / H_ACTIVE;
    bar     = (barIdx > 32'd7) ? 3'd7 : 3'(barIdx);
    case (mode)
      CAM_MODE_BARS:  pixWord = CAM_BAR_COLOR[bar];
      CAM_MODE_FIXED: pixWord = fixedPx;
      CAM_MODE_STAMP: pixWord = (x == 32'd0) ? 16'(frameCnt) : y[15:0];
      default:        pixWord = 16'd0;
    endcase
    // Only a 16-bit word exists for these modes; bytes past the second are zero.
    case (b)
      2'd0:    pixByte = pixWord[15:8];
      2'd1:    pixByte = pixWord[7:0];
      default: pixByte = 8'd0;
    endcase
    data = (mode == CAM_MODE_RAMP) ? DW'(rampVal) : DW'(pixByte);
  end

endmodule

// File: rtl/cam_frame_gen.sv
// Synthetic OV-style camera source: frame FSM, h/v counters and registered
// VSYNC/HREF/DATA outputs with start/stop, one-shot and frame counting.
module cam_frame_gen
  import cam_pkg::*;
#(
  parameter int DW       = 8,
  parameter int H_ACTIVE = 640,
  parameter int BPP      = 2,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int FCW      = 16
) (
  input  logic           PCLK,
  input  logic           reset_n,
  input  logic           enable,
  input  logic           single,
  input  logic [1:0]     mode,
  input  logic [15:0]    fixed_px,
  output logic           VSYNC,
  output logic           HREF,
  output logic [DW-1:0]  DATA,
  output logic           busy,
  output logic           frame_done,
  output logic [FCW-1:0] frame_cnt,
  output logic           stateDbg
);

  localparam int LT          = LINE_T(H_ACTIVE, BPP, H_BLANK);
  localparam int FL          = FRAME_L(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  localparam int HW          = (LT > 1) ? $clog2(LT) : 1;
  localparam int VW          = (FL > 1) ? $clog2(FL) : 1;
  localparam int ACT_BYTES   = H_ACTIVE * BPP;
  localparam int V_ACT_START = V_SYNC + V_BACK;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  logic          armed;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [1:0]    modeLat;
  logic [15:0]   fixedLat;

  logic [31:0]   hc32, vc32, pixX, pixY;
  logic [1:0]    pixB;
  logic          lastH, lastV, vsyncNext, hrefNext;
  logic [DW-1:0] patByte;

  assign stateDbg = state;

  always_comb begin
    hc32      = 32'(hcnt);
    vc32      = 32'(vcnt);
    lastH     = (hc32 == LT - 1);
    lastV     = (vc32 == FL - 1);
    vsyncNext = (vc32 < V_SYNC);
    hrefNext  = (hc32 < ACT_BYTES) && (vc32 >= V_ACT_START) && (vc32 < V_ACT_END);
    pixX      = hc32 / BPP;
    pixB      = 2'(hc32 % BPP);
    pixY      = vc32 - V_ACT_START;
  end

  cam_pattern_gen #(
    .DW(DW), .H_ACTIVE(H_ACTIVE), .BPP(BPP), .FCW(FCW)
  ) uPattern (
    .x(pixX), .b(pixB), .y(pixY), .mode(modeLat), .fixedPx(fixedLat),
    .frameCnt(frame_cnt), .data(patByte)
  );

  always_ff @(posedge PCLK) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      armed      <= 1'b1;
      hcnt       <= '0;
      vcnt       <= '0;
      modeLat    <= CAM_MODE_RAMP;
      fixedLat   <= '0;
      VSYNC      <= 1'b0;
      HREF       <= 1'b0;
      DATA       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          VSYNC <= 1'b0;
          HREF  <= 1'b0;
          DATA  <= '0;
          // Re-arm after a one-shot only once the requester lets go of enable.
          if (!enable) armed <= 1'b1;
          if (enable && armed) begin
            state    <= ST_RUN;
            hcnt     <= '0;
            vcnt     <= '0;
            busy     <= 1'b1;
            modeLat  <= mode;
            fixedLat <= fixed_px;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RUN: begin
          VSYNC <= vsyncNext;
          HREF  <= hrefNext;
          DATA  <= hrefNext ? patByte : '0;
          if (lastH && lastV) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + FCW'(1);
            hcnt       <= '0;
            vcnt       <= '0;
            if (single) armed <= 1'b0;
            // Continuous run restarts on the very next cycle with fresh settings.
            if (enable && !single) begin
              modeLat  <= mode;
              fixedLat <= fixed_px;
            end else begin
              state <= ST_IDLE;
            end
          end else if (lastH) begin
            hcnt <= '0;
            vcnt <= vcnt + VW'(1);
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_frame_gen.sv
// Self-checking bench for cam_frame_gen on a tiny 20x7 geometry (140 cycles/frame).
module tb_cam_frame_gen;

  localparam int H_ACT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, enable, single;
  logic [1:0]  mode;
  logic [15:0] fixed_px;
  logic        VSYNC, HREF, busy, frame_done, state_dbg;
  logic [7:0]  DATA;
  logic [15:0] frame_cnt;

  logic        reset2_n, enable2;
  logic        vs2, href2, busy2, done2, st2;
  logic [7:0]  data2;
  logic [1:0]  cnt2;

  cam_frame_gen #(
    .DW(8), .H_ACTIVE(H_ACT), .BPP(2), .H_BLANK(4), .V_SYNC(1), .V_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .FCW(16)
  ) dut (
    .PCLK(clk), .reset_n(reset_n), .enable(enable), .single(single), .mode(mode),
    .fixed_px(fixed_px), .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .stateDbg(state_dbg)
  );

  cam_frame_gen #(
    .DW(8), .H_ACTIVE(H_ACT), .BPP(2), .H_BLANK(4), .V_SYNC(1), .V_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .FCW(2)
  ) dut2 (
    .PCLK(clk), .reset_n(reset2_n), .enable(enable2), .single(1'b0), .mode(2'd0),
    .fixed_px(16'h0000), .VSYNC(vs2), .HREF(href2), .DATA(data2), .busy(busy2),
    .frame_done(done2), .frame_cnt(cnt2), .stateDbg(st2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int done_rel_q[$], done_cnt_q[$], vs_rise_q[$], cnt2_q[$];
  int href_cnt = 0, vs_high = 0, first_href = -1, leak_cnt = 0;
  int cap_frm = -1, cap_line = 0, cap_byte = 0;
  logic vs_prev = 1'b0;
  logic [7:0] cap [4][4][16];

  logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  typedef struct {
    int tst;
    int frm;
    int line;
    int idx;
    int exp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input int md, input logic [15:0] fx,
                                            input int fcnt, input int h, input int y);
    logic [15:0] pix;
    int x;
    x = h / 2;
    pix = 16'h0000;
    case (md)
      0: return 8'((h + y) % 256);
      1: pix = bar_tab[x * 8 / H_ACT];
      2: pix = fx;
      default: pix = (x == 0) ? 16'(fcnt) : 16'(y);
    endcase
    return (h % 2 == 0) ? pix[15:8] : pix[7:0];
  endfunction

  task automatic push_frame(input int md, input logic [15:0] fx, input int fcnt);
    for (int y = 0; y < 4; y++)
      for (int h = 0; h < 16; h++)
        exp_q.push_back(model_byte(md, fx, fcnt, h, y));
  endtask

  task automatic add_vec(input int t, input int f, input int l, input int i, input int e);
    vec_t v;
    v.tst = t; v.frm = f; v.line = l; v.idx = i; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check_table(input int tst);
    foreach (vecs[i])
      if (vecs[i].tst == tst)
        chk($sformatf("t%0d_tab_f%0d_l%0d_b%0d", tst, vecs[i].frm, vecs[i].line, vecs[i].idx),
            int'(cap[vecs[i].frm][vecs[i].line][vecs[i].idx]), vecs[i].exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rel(input int r);
    while (cyc - base < r) tick(1);
  endtask

  task automatic clear_logs();
    exp_q.delete();
    vs_rise_q.delete();
    done_rel_q.delete();
    done_cnt_q.delete();
    href_cnt = 0; vs_high = 0; first_href = -1;
    cap_frm = -1; cap_line = 0; cap_byte = 0;
  endtask

  task automatic do_reset();
    enable = 1'b0; single = 1'b0; mode = 2'd0; fixed_px = 16'h0000;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    clear_logs();
  endtask

  // Passive monitor: scoreboard pops on every HREF byte, event logs for the tests.
  always @(negedge clk) begin
    int rel;
    logic [7:0] e;
    rel = cyc - base;
    if (VSYNC && !vs_prev) begin
      vs_rise_q.push_back(rel);
      cap_frm++;
      cap_line = 0;
      cap_byte = 0;
    end
    vs_prev = VSYNC;
    if (VSYNC) vs_high++;
    if (!HREF && DATA != 8'h00) leak_cnt++;
    if (HREF) begin
      href_cnt++;
      if (first_href < 0) first_href = rel;
      if (cap_frm >= 0 && cap_frm < 4 && cap_line < 4) cap[cap_frm][cap_line][cap_byte] = DATA;
      cap_byte++;
      if (cap_byte == 16) begin
        cap_byte = 0;
        cap_line++;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=byte 0x%0h with HREF required=no HREF (rel %0d)", DATA, rel);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("sb_data_rel%0d", rel), int'(DATA), int'(e));
      end
    end
    if (frame_done) begin
      done_rel_q.push_back(rel);
      done_cnt_q.push_back(int'(frame_cnt));
    end
    if (done2) cnt2_q.push_back(int'(cnt2));
  end

  initial begin
    int bh;
    add_vec(1, 0, 0, 0, 8'h00); add_vec(1, 0, 2, 0, 8'h02);
    add_vec(1, 0, 2, 15, 8'h11); add_vec(1, 0, 3, 15, 8'h12);
    add_vec(2, 0, 0, 0, 8'hFF); add_vec(2, 0, 0, 1, 8'hFF);
    add_vec(2, 0, 0, 2, 8'hFF); add_vec(2, 0, 0, 3, 8'hE0);
    add_vec(2, 0, 0, 4, 8'h07); add_vec(2, 0, 0, 5, 8'hFF);
    add_vec(2, 0, 0, 8, 8'hF8); add_vec(2, 0, 0, 9, 8'h1F);
    add_vec(2, 0, 0, 14, 8'h00); add_vec(2, 0, 0, 15, 8'h00);
    add_vec(2, 1, 2, 0, 8'h00); add_vec(2, 1, 2, 1, 8'h01);
    add_vec(2, 1, 2, 2, 8'h00); add_vec(2, 1, 2, 3, 8'h02);
    add_vec(2, 1, 2, 15, 8'h02);
    add_vec(5, 0, 0, 0, 8'hA5); add_vec(5, 0, 0, 1, 8'h5A);
    add_vec(5, 0, 3, 14, 8'hA5); add_vec(5, 0, 3, 15, 8'h5A);
    add_vec(5, 1, 2, 0, 8'h02); add_vec(5, 1, 1, 3, 8'h04);

    reset2_n = 1'b0; enable2 = 1'b0;
    enable = 1'b0; single = 1'b0; mode = 2'd0; fixed_px = 16'h0000; reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    chk("reset_outputs", int'({VSYNC, HREF, DATA, busy, frame_done, state_dbg}), 0);
    chk("reset_frame_cnt", int'(frame_cnt), 0);

    // 1: single ramp frame, timing landmarks
    clear_logs();
    push_frame(0, 16'h0, 0);
    base = cyc + 1; enable = 1'b1;
    tick(1);
    chk("t1_busy_c0", int'(busy), 1);
    chk("t1_vsync_c0", int'(VSYNC), 0);
    tick(1);
    chk("t1_vsync_c1", int'(VSYNC), 1);
    wait_rel(5); enable = 1'b0;
    wait_rel(140);
    chk("t1_done_c140", int'(frame_done), 1);
    chk("t1_busy_c140", int'(busy), 1);
    chk("t1_cnt_c140", int'(frame_cnt), 1);
    tick(1);
    chk("t1_done_c141", int'(frame_done), 0);
    chk("t1_busy_c141", int'(busy), 0);
    wait_rel(160);
    chk("t1_vs_rise", vs_rise_q.size() == 1 ? vs_rise_q[0] : -1, 1);
    chk("t1_vs_high", vs_high, 20);
    chk("t1_first_href", first_href, 41);
    chk("t1_href_cnt", href_cnt, 64);
    chk("t1_done_rel", done_rel_q.size() == 1 ? done_rel_q[0] : -1, 140);
    chk("t1_sb_left", exp_q.size(), 0);
    check_table(1);

    // 2: colour bars, then stamp frame back to back
    do_reset();
    mode = 2'd1;
    push_frame(1, 16'h0, 0);
    base = cyc + 1; enable = 1'b1;
    wait_rel(70); mode = 2'd3;
    push_frame(3, 16'h0, 1);
    wait_rel(150); enable = 1'b0;
    wait_rel(300);
    chk("t2_href_cnt", href_cnt, 128);
    chk("t2_frames", done_rel_q.size(), 2);
    chk("t2_done2_rel", done_rel_q.size() == 2 ? done_rel_q[1] : -1, 280);
    chk("t2_sb_left", exp_q.size(), 0);
    check_table(2);

    // 3: one-shot with enable held, then re-arm
    do_reset();
    single = 1'b1;
    push_frame(0, 16'h0, 0);
    base = cyc + 1; enable = 1'b1;
    wait_rel(141);
    chk("t3_busy_after", int'(busy), 0);
    bh = 0;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (busy) bh++;
    end
    chk("t3_idle_busy", bh, 0);
    chk("t3_idle_vsync", vs_high, 20);
    chk("t3_idle_state", int'(state_dbg), 0);
    enable = 1'b0;
    tick(2);
    push_frame(0, 16'h0, 1);
    base = cyc + 1; enable = 1'b1;
    wait_rel(145);
    chk("t3_frames", done_cnt_q.size(), 2);
    chk("t3_cnt", done_cnt_q.size() == 2 ? done_cnt_q[1] : -1, 2);
    chk("t3_done_rel", done_rel_q.size() == 2 ? done_rel_q[1] : -1, 140);
    chk("t3_busy_end", int'(busy), 0);
    enable = 1'b0; single = 1'b0;

    // 4: enable dropped inside the first active line
    do_reset();
    push_frame(0, 16'h0, 0);
    base = cyc + 1; enable = 1'b1;
    wait_rel(45); enable = 1'b0;
    wait_rel(420);
    chk("t4_frames", done_rel_q.size(), 1);
    chk("t4_done_rel", done_rel_q.size() == 1 ? done_rel_q[0] : -1, 140);
    chk("t4_vs_rises", vs_rise_q.size(), 1);
    chk("t4_href_cnt", href_cnt, 64);
    chk("t4_busy_end", int'(busy), 0);

    // 5: fixed then ramp; mid-frame setting changes must wait for the next frame
    do_reset();
    mode = 2'd2; fixed_px = 16'hA55A;
    push_frame(2, 16'hA55A, 0);
    base = cyc + 1; enable = 1'b1;
    wait_rel(70); mode = 2'd0; fixed_px = 16'h1234;
    push_frame(0, 16'h0, 1);
    wait_rel(150); enable = 1'b0;
    wait_rel(300);
    chk("t5_no_gap", vs_rise_q.size() == 2 ? vs_rise_q[1] : -1, 141);
    chk("t5_done1_rel", done_rel_q.size() == 2 ? done_rel_q[0] : -1, 140);
    chk("t5_done2_rel", done_rel_q.size() == 2 ? done_rel_q[1] : -1, 280);
    chk("t5_sb_left", exp_q.size(), 0);
    check_table(5);

    // 6: reset asserted in the middle of an active line
    do_reset();
    push_frame(0, 16'h0, 0);
    push_frame(0, 16'h0, 1);
    base = cyc + 1; enable = 1'b1;
    wait_rel(190);
    chk("t6_cnt_before", int'(frame_cnt), 1);
    chk("t6_href_before", int'(HREF), 1);
    reset_n = 1'b0;
    tick(1);
    chk("t6_outputs", int'({VSYNC, HREF, DATA, busy, frame_done, state_dbg}), 0);
    chk("t6_cnt", int'(frame_cnt), 0);
    enable = 1'b0; reset_n = 1'b1;
    exp_q.delete();
    tick(2);

    // 7: 2-bit frame counter wraps
    reset2_n = 1'b1;
    tick(1);
    enable2 = 1'b1;
    tick(4 * 140 + 20);
    enable2 = 1'b0;
    tick(160);
    chk("t7_frames", cnt2_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      int exp_c;
      exp_c = (i + 1) % 4;
      chk($sformatf("t7_cnt_%0d", i), cnt2_q.size() > i ? cnt2_q[i] : -1, exp_c);
    end

    chk("data_leak", leak_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
